// File: rtl/piso_pkg.sv
// Shared types and bit-order encodings for the PISO shift register.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int unsigned MSB_FIRST = 0;
  localparam int unsigned LSB_FIRST = 1;

endpackage

// File: rtl/piso_shift_reg_if.sv
// Parallel ready/valid port plus strobed serial output of the PISO shift register.
interface piso_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             ser_en;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output par_data, par_valid, ser_en,
    input  par_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  par_data, par_valid, ser_en,
    output par_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/dff_ar.sv
// Width-parametrised D register with enable and asynchronous active-high reset.
module dff_ar #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shifter with a one-word holding buffer for gapless streaming.
module piso_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input logic             clk,
  input logic             rst,
  piso_shift_reg_if.slave bus
);
  import piso_pkg::*;

  localparam int unsigned CW      = $clog2(WIDTH);
  localparam bit          MSB_OUT = (LSB_FIRST == MSB_FIRST);

  piso_state_t      state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d, sreg_shift, hold;
  logic [CW-1:0]    cnt, cnt_d;
  logic             hold_full, hold_full_d;
  logic             accept, drain;

  assign accept     = bus.par_valid && !hold_full;
  assign sreg_shift = MSB_OUT ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  dff_ar #(.WIDTH(WIDTH)) u_hold (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (bus.par_data),
    .q   (hold)
  );

  // Next state: load from hold when idle or on the last bit, otherwise shift on strobe
  always_comb begin
    state_d     = state;
    sreg_d      = sreg;
    cnt_d       = cnt;
    drain       = 1'b0;
    hold_full_d = hold_full;
    case (state)
      IDLE: begin
        if (hold_full) begin
          sreg_d  = hold;
          cnt_d   = CW'(WIDTH - 1);
          drain   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_en) begin
          if (cnt != '0) begin
            sreg_d = sreg_shift;
            cnt_d  = cnt - CW'(1);
          end else if (hold_full) begin
            sreg_d = hold;
            cnt_d  = CW'(WIDTH - 1);
            drain  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (drain) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      cnt       <= cnt_d;
      hold_full <= hold_full_d;
    end
  end

  // Outputs decode registers only
  assign bus.par_ready = !hold_full;
  assign bus.ser_valid = (state == SHIFT);
  assign bus.ser_out   = (state == SHIFT) && (MSB_OUT ? sreg[WIDTH-1] : sreg[0]);
  assign bus.ser_first = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign bus.ser_last  = (state == SHIFT) && (cnt == '0);
  assign bus.busy      = hold_full || (state == SHIFT);

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench: MSB-first and LSB-first instances driven with identical stimulus.
module tb_piso_shift_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  piso_shift_reg_if #(.WIDTH(8)) bus_m ();
  piso_shift_reg_if #(.WIDTH(8)) bus_l ();

  piso_shift_reg #(.WIDTH(8), .LSB_FIRST(0)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
  piso_shift_reg #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    bus_m.par_data  = d;
    bus_l.par_data  = d;
    bus_m.par_valid = v;
    bus_l.par_valid = v;
    bus_m.ser_en    = e;
    bus_l.ser_en    = e;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready_m"}, 32'(bus_m.par_ready), 32'd1);
    chk({tag, "_valid_m"}, 32'(bus_m.ser_valid), 32'd0);
    chk({tag, "_out_m"},   32'(bus_m.ser_out),   32'd0);
    chk({tag, "_first_m"}, 32'(bus_m.ser_first), 32'd0);
    chk({tag, "_last_m"},  32'(bus_m.ser_last),  32'd0);
    chk({tag, "_busy_m"},  32'(bus_m.busy),      32'd0);
    chk({tag, "_ready_l"}, 32'(bus_l.par_ready), 32'd1);
    chk({tag, "_valid_l"}, 32'(bus_l.ser_valid), 32'd0);
    chk({tag, "_out_l"},   32'(bus_l.ser_out),   32'd0);
    chk({tag, "_busy_l"},  32'(bus_l.busy),      32'd0);
  endtask

  // Bit i of word w in shift order, checked on both bit orders
  task automatic check_bit(input string tag, input logic [7:0] w, input int i);
    chk({tag, "_valid"},   32'(bus_m.ser_valid), 32'd1);
    chk({tag, "_msb_out"}, 32'(bus_m.ser_out),   32'(w[7-i]));
    chk({tag, "_lsb_out"}, 32'(bus_l.ser_out),   32'(w[i]));
    chk({tag, "_first_m"}, 32'(bus_m.ser_first), 32'(i == 0));
    chk({tag, "_last_m"},  32'(bus_m.ser_last),  32'(i == 7));
    chk({tag, "_first_l"}, 32'(bus_l.ser_first), 32'(i == 0));
    chk({tag, "_last_l"},  32'(bus_l.ser_last),  32'(i == 7));
  endtask

  // Single word with ser_en held high: first bit visible two edges after par_valid
  task automatic run_single(input logic [7:0] w);
    drive(w, 1'b1, 1'b1);
    @(negedge clk);
    chk("single_ready_after_accept", 32'(bus_m.par_ready), 32'd0);
    chk("single_valid_after_accept", 32'(bus_m.ser_valid), 32'd0);
    chk("single_busy_after_accept",  32'(bus_m.busy),      32'd1);
    drive(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check_bit("single", w, i);
      @(negedge clk);
    end
    chk_idle("single_done");
  endtask

  logic [7:0] words [3];
  logic [7:0] cur;
  int         idx;
  int         bits;
  int         vcnt;
  bit         started;

  initial begin
    checks   = 0;
    failures = 0;
    words[0] = 8'h3C;
    words[1] = 8'hFF;
    words[2] = 8'h01;
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    // ser_en with nothing pending
    drive(8'h00, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk_idle("idle_en");
    end

    run_single(8'hA5);
    run_single(8'h4D);

    // Stream three words with par_valid held high
    idx     = 0;
    bits    = 0;
    started = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus_m.ser_valid) begin
        started = 1'b1;
        if (bits < 24) begin
          cur = words[bits / 8];
          check_bit("stream", cur, bits % 8);
        end
        bits++;
      end else if (started && bits < 24) begin
        chk("stream_gap", 32'(bus_m.ser_valid), 32'd1);
      end
      if (idx < 3) begin
        drive(words[idx], 1'b1, 1'b1);
        if (bus_m.par_ready) idx++;
      end else begin
        drive(8'h00, 1'b0, 1'b1);
      end
      @(negedge clk);
    end
    chk("stream_words_accepted", 32'(idx), 32'd3);
    chk("stream_bits", 32'(bits), 32'd24);
    chk_idle("stream_done");

    // One strobe every four cycles
    drive(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 4; p++) begin
        check_bit("slow", 8'h81, i);
        drive(8'h00, 1'b0, p == 3);
        @(negedge clk);
      end
    end
    chk_idle("slow_done");

    // Reset while bit 3 is on the line and another word is held
    drive(8'hF0, 1'b1, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h55, 1'b1, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check_bit("pre_rst", 8'hF0, 3);
    chk("pre_rst_hold_full", 32'(bus_m.par_ready), 32'd0);
    #1 rst = 1'b1;
    #1 chk_idle("rst_mid");
    @(negedge clk);
    rst  = 1'b0;
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_m.ser_valid || bus_l.ser_valid || bus_m.busy) vcnt++;
    end
    chk("post_rst_no_output", 32'(vcnt), 32'd0);
    chk_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parametrised parallel-in/serial-out shift register with a ready/valid parallel port, a one-word holding buffer, and a strobed serial output. It is the next generation of the single-bit D flip-flop stage in the PISO design. It sits between a word-producing source and a bit-serial sink, such as a UART-style transmitter or a pin driver. Back-to-back words stream with no idle bit slot between them.

## Interface
- WIDTH, 8, parallel word width in bits; must be ≥ 2
- LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB shifted out first
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- par_data  in  WIDTH  parallel word
- par_valid  in  1  source offers par_data
- par_ready  out  1  holding buffer empty; equals !hold_full, driven only from registers
- ser_en  in  1  bit strobe; one bit consumed per clk edge with ser_en=1 while ser_valid=1
- ser_out  out  1  current serial bit; 0 when ser_valid=0
- ser_valid  out  1  shifter holds a word (state SHIFT)
- ser_first  out  1  ser_valid and current bit is bit 0 of the word in shift order
- ser_last  out  1  ser_valid and current bit is the final bit of the word
- busy  out  1  hold_full or state SHIFT

## Operation
- Storage:
  - hold register, WIDTH bits, with hold_full flag
  - shift register sreg, WIDTH bits
  - bit counter cnt, $clog2(WIDTH) bits
  - state ∈ {IDLE, SHIFT}
- Accept: when par_valid && par_ready at an edge, hold ← par_data and hold_full ← 1. Data is never accepted while hold_full=1.
- Bit selection: ser_out = sreg[WIDTH-1] when LSB_FIRST=0, otherwise sreg[0].
- On consume, sreg shifts toward the output end with 0 fill and cnt decrements.
- IDLE:
  - ser_en is ignored.
  - If hold_full: sreg ← hold, cnt ← WIDTH-1, hold_full ← 0, state ← SHIFT.
- SHIFT, consume with cnt ≠ 0: shift only.
- SHIFT, consume with cnt = 0 (last bit):
  - If hold_full: sreg ← hold, cnt ← WIDTH-1, hold_full ← 0, state stays SHIFT. This is the gapless path.
  - Otherwise: state ← IDLE.
- SHIFT without consume: all state holds.
- Simultaneous accept and hold-drain in the same cycle cannot occur, because accept requires hold_full=0.
- Derived outputs:
  - ser_first = ser_valid && cnt == WIDTH-1
  - ser_last = ser_valid && cnt == 0
- Reset, including mid-word: the in-flight word and the held word are discarded. There is no partial output after reset release.

## Timing
- Reset values: par_ready=1, ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0. Internally sreg=0, hold=0, cnt=0, state IDLE.
- From an accept edge N while IDLE, the load happens at edge N+1. ser_valid and ser_first are high after edge N+1. First-bit latency is 2 edges from par_valid sampled high.
- A word occupies exactly WIDTH consume edges. With ser_en held at 1, ser_valid stays high continuously across consecutive words when the hold is refilled in time.
- par_ready rises the cycle after the hold drains. A new word accepted any time before the current word's last consume edge keeps the stream gapless.
- Outputs are purely registered or a simple decode of registers. There is no combinational path from any input to any output.

## Structure
- Package piso_pkg contains:
  - typedef piso_state_t {IDLE, SHIFT}
  - localparam encodings for LSB_FIRST (MSB_FIRST=0, LSB_FIRST=1)
- Sub-module dff_ar: a parametrised-width D register with async active-high reset and enable (ports clk, rst, en, d, q). It is instantiated for the hold register.
- The remainder is one always_ff block for the FSM, counter and shifter, plus continuous output decode.

## Test plan
- Reset, then hold rst=1 → all outputs at their reset values. Assert rst mid-word at bit 3 → ser_valid=0 and par_ready=1 immediately, and no bits emerge after release.
- WIDTH=8, LSB_FIRST=0, send 0xA5 with ser_en=1 → ser_out sequence 1,0,1,0,0,1,0,1. ser_first on bit 0, ser_last on bit 7, ser_valid for exactly 8 cycles, first bit 2 edges after par_valid.
- LSB_FIRST=1, send 0xA5 → ser_out sequence 1,0,1,0,0,1,0,1 read LSB first (bits 0..7 = 1,0,1,0,0,1,0,1), with first/last markers correct.
- Stream 0x3C, 0xFF, 0x01 with par_valid always high and ser_en=1 → 24 contiguous ser_valid cycles with no gap. par_ready low while hold_full, and each word is accepted exactly once.
- ser_en toggled 1-in-4, send 0x81 → each bit is held 4 cycles, and state/cnt are unchanged on cycles with ser_en=0.
- ser_en high while IDLE with nothing pending → ser_out=0, ser_valid=0, busy=0, and no counter movement.
